// File: rtl/serial_sum_acc_if.sv
// serial_sum_acc_if: start/bit-pair handshake and result bundle for serial_sum_acc.
interface serial_sum_acc_if #(parameter int WIDTH = 8);
   logic             start;
   logic             bit_valid;
   logic             hs_sum;
   logic             hs_carry;
   logic             bit_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             busy;
   logic             done;
   modport master (
      output start, bit_valid, hs_sum, hs_carry,
      input  bit_ready, result, carry_out, busy, done
   );
   modport slave (
      input  start, bit_valid, hs_sum, hs_carry,
      output bit_ready, result, carry_out, busy, done
   );
endinterface

// File: rtl/serial_sum_acc.sv
// serial_sum_acc: LSB-first serial adder completing half-adder bit pairs into a WIDTH-bit sum.
// Define SERIAL_SUM_ACC_SAT_EN to saturate result to all-ones on overflow.
module serial_sum_acc #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   serial_sum_acc_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int CW = $clog2(WIDTH);
   state_t           state;
   logic [CW-1:0]    cnt;
   logic             cin;
   logic [WIDTH-1:0] sh;
   logic             fsum, ncin, acc, last;
   logic [WIDTH-1:0] nsh;
   always_comb begin
      fsum = bus.hs_sum ^ cin;
      ncin = bus.hs_carry | (bus.hs_sum & cin);
      acc  = bus.bit_valid && state == RUN;
      last = cnt == CW'(WIDTH - 1);
      nsh  = {fsum, sh[WIDTH-1:1]};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         cin           <= 1'b0;
         sh            <= '0;
         bus.result    <= '0;
         bus.carry_out <= 1'b0;
         bus.bit_ready <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               state         <= RUN;
               cnt           <= '0;
               cin           <= 1'b0;
               sh            <= '0;
               bus.bit_ready <= 1'b1;
               bus.busy      <= 1'b1;
            end
         end else if (state == RUN) begin
            if (acc) begin
               sh  <= nsh;
               cin <= ncin;
               cnt <= last ? cnt : cnt + 1'b1;
               if (last) begin
                  state         <= DONE;
                  bus.bit_ready <= 1'b0;
                  bus.done      <= 1'b1;
                  bus.carry_out <= ncin;
`ifdef SERIAL_SUM_ACC_SAT_EN
                  bus.result    <= ncin ? '1 : nsh;
`else
                  bus.result    <= nsh;
`endif
               end
            end
         end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_serial_sum_acc.sv
// tb_serial_sum_acc: directed vectors for serial_sum_acc at WIDTH=8.
module tb_serial_sum_acc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc;
   serial_sum_acc_if #(.WIDTH(8)) bus();
   serial_sum_acc #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
`ifdef SERIAL_SUM_ACC_SAT_EN
   localparam logic [7:0] R_OVF1 = 8'hFF;
   localparam logic [7:0] R_OVF2 = 8'hFF;
`else
   localparam logic [7:0] R_OVF1 = 8'h2C;
   localparam logic [7:0] R_OVF2 = 8'h00;
`endif
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Starts at a negedge; returns at the negedge after the last accept (done cycle).
   task automatic add(input logic [7:0] a, input logic [7:0] b, input bit stall,
                      input bit hold_start, input logic [7:0] prev, output int c);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = hold_start;
      c = 1;
      chk("run_busy", 16'(bus.busy), 16'd1);
      chk("run_ready", 16'(bus.bit_ready), 16'd1);
      chk("prev_held", 16'(bus.result), 16'(prev));
      for (int i = 0; i < 8; i++) begin
         if (stall) begin
            bus.bit_valid = 1'b0;
            @(negedge clk);
            c++;
         end
         bus.bit_valid = 1'b1;
         bus.hs_sum    = a[i] ^ b[i];
         bus.hs_carry  = a[i] & b[i];
         if (i < 7) chk("no_early_done", 16'(bus.done), 16'd0);
         @(negedge clk);
         c++;
      end
      bus.bit_valid = 1'b0;
   endtask
   task automatic finish_chk(input string tag, input logic [7:0] r, input logic c_out,
                             input int c, input int c_exp);
      chk({tag, "_done"}, 16'(bus.done), 16'd1);
      chk({tag, "_result"}, 16'(bus.result), 16'(r));
      chk({tag, "_carry"}, 16'(bus.carry_out), 16'(c_out));
      chk({tag, "_latency"}, 16'(c), 16'(c_exp));
      chk({tag, "_ready_done"}, 16'(bus.bit_ready), 16'd0);
      bus.start = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 16'(bus.done), 16'd0);
      chk({tag, "_busy_fall"}, 16'(bus.busy), 16'd0);
      chk({tag, "_result_hold"}, 16'(bus.result), 16'(r));
   endtask
   initial begin
      bus.start = 1'b0; bus.bit_valid = 1'b0; bus.hs_sum = 1'b0; bus.hs_carry = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 16'(bus.bit_ready), 16'd0);
      chk("rst_busy", 16'(bus.busy), 16'd0);
      chk("rst_done", 16'(bus.done), 16'd0);
      chk("rst_result", 16'(bus.result), 16'd0);
      chk("rst_carry", 16'(bus.carry_out), 16'd0);
      rst = 1'b0;
      @(negedge clk);
      // Bit pairs offered in IDLE must be ignored.
      bus.bit_valid = 1'b1; bus.hs_sum = 1'b1;
      @(negedge clk);
      chk("idle_ready", 16'(bus.bit_ready), 16'd0);
      chk("idle_busy", 16'(bus.busy), 16'd0);
      bus.bit_valid = 1'b0;
      add(8'd3, 8'd5, 1'b0, 1'b0, 8'h00, cyc);
      finish_chk("a3b5", 8'h08, 1'b0, cyc, 9);
      add(8'd200, 8'd100, 1'b0, 1'b0, 8'h08, cyc);
      finish_chk("a200b100", R_OVF1, 1'b1, cyc, 9);
      add(8'hFF, 8'h01, 1'b1, 1'b0, R_OVF1, cyc);
      finish_chk("stall", R_OVF2, 1'b1, cyc, 17);
      add(8'h10, 8'h20, 1'b0, 1'b1, R_OVF2, cyc);
      finish_chk("hold_start", 8'h30, 1'b0, cyc, 9);
      // Abort mid-run after four accepted bits.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.bit_valid = 1'b1; bus.hs_sum = 1'b1; bus.hs_carry = 1'b1;
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      chk("arst_busy", 16'(bus.busy), 16'd0);
      chk("arst_ready", 16'(bus.bit_ready), 16'd0);
      chk("arst_result", 16'(bus.result), 16'd0);
      chk("arst_carry", 16'(bus.carry_out), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.bit_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_done", 16'(bus.done), 16'd0);
      // start with a bit pair present: the bit must not be taken in IDLE.
      bus.bit_valid = 1'b1; bus.hs_sum = 1'b1; bus.hs_carry = 1'b1;
      add(8'd1, 8'd1, 1'b0, 1'b0, 8'h00, cyc);
      finish_chk("a1b1", 8'h02, 1'b0, cyc, 9);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
